// File: rtl/i2c_read_byte.sv
// I2C single-register read master: START, addr+W, pointer, repeated START, addr+R,
// one data byte closed by a master NACK, then STOP. One bus phase per PT_CK cycle.
module i2c_read_byte #(
  parameter bit         NACK_ABORT = 1'b1,
  parameter logic [7:0] RDATA_INIT = 8'h00
) (
  input  logic       PT_CK,
  input  logic       RESET,
  input  logic       GO,
  input  logic [7:0] SLAVE_ADDRESS,
  input  logic [7:0] POINTER,
  input  logic       SDAI,
  output logic       SDAO,
  output logic       SCLO,
  output logic       END_OK,
  output logic [7:0] RDATA8,
  output logic       RD_VALID,
  output logic       ACK_OK
);

  typedef enum logic [3:0] {
    IDLE, WAIT_LOW, START_A, START_B,
    B_SETUP, B_HIGH, B_LOW,
    RS_A, RS_B, RS_C, RS_D,
    STOP_A, STOP_B, STOP_C, DONE
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] bitCnt_q, bitCnt_d;
  logic [1:0] byteIdx_q, byteIdx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] rdata_q, rdata_d;
  logic       ackFlag_q, ackFlag_d;
  logic       endOk_q, endOk_d;
  logic       rdValid_q, rdValid_d;
  logic       ackOk_q, ackOk_d;

  logic [7:0] txByte;
  logic       txBit;
  logic       lastCell;
  logic       sdaDrive;
  logic       sclDrive;
  logic       unusedAddrBit;

  // The R/W bit is inserted here, so the caller's bit 0 is deliberately dropped.
  assign unusedAddrBit = SLAVE_ADDRESS[0];

  always_comb begin
    case (byteIdx_q)
      2'd0:    txByte = {SLAVE_ADDRESS[7:1], 1'b0};
      2'd1:    txByte = POINTER;
      default: txByte = {SLAVE_ADDRESS[7:1], 1'b1};
    endcase
  end

  assign lastCell = (bitCnt_q == 4'd8);
  // The ACK slot and every cell of the data byte leave SDA released for the slave.
  assign txBit    = (lastCell || byteIdx_q == 2'd3) ? 1'b1 : txByte[~bitCnt_q[2:0]];

  always_ff @(posedge PT_CK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      byteIdx_q <= '0;
      shift_q   <= '0;
      rdata_q   <= RDATA_INIT;
      ackFlag_q <= 1'b0;
      endOk_q   <= 1'b1;
      rdValid_q <= 1'b0;
      ackOk_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      byteIdx_q <= byteIdx_d;
      shift_q   <= shift_d;
      rdata_q   <= rdata_d;
      ackFlag_q <= ackFlag_d;
      endOk_q   <= endOk_d;
      rdValid_q <= rdValid_d;
      ackOk_q   <= ackOk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    byteIdx_d = byteIdx_q;
    shift_d   = shift_q;
    rdata_d   = rdata_q;
    ackFlag_d = ackFlag_q;
    endOk_d   = endOk_q;
    rdValid_d = 1'b0;
    ackOk_d   = ackOk_q;
    sdaDrive  = 1'b1;
    sclDrive  = 1'b1;

    case (state_q)
      IDLE: begin
        if (GO) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!GO) begin
          state_d = START_A;
          endOk_d = 1'b0;
        end
      end
      START_A: begin
        sdaDrive  = 1'b0;
        ackFlag_d = 1'b1;
        bitCnt_d  = '0;
        byteIdx_d = '0;
        state_d   = START_B;
      end
      START_B: begin
        sdaDrive = 1'b0;
        sclDrive = 1'b0;
        state_d  = B_SETUP;
      end
      B_SETUP: begin
        sclDrive = 1'b0;
        sdaDrive = txBit;
        state_d  = B_HIGH;
      end
      // SDAI is captured on the edge that drops SCL, i.e. the level seen while SCL was high.
      B_HIGH: begin
        sdaDrive = txBit;
        state_d  = B_LOW;
        if (byteIdx_q == 2'd3) begin
          if (!lastCell) shift_d = {shift_q[6:0], SDAI};
        end else if (lastCell && SDAI) begin
          ackFlag_d = 1'b0;
        end
      end
      B_LOW: begin
        sclDrive = 1'b0;
        sdaDrive = txBit;
        if (!lastCell) begin
          bitCnt_d = bitCnt_q + 4'd1;
          state_d  = B_SETUP;
        end else begin
          bitCnt_d = '0;
          if (byteIdx_q == 2'd3) begin
            rdata_d   = shift_q;
            rdValid_d = 1'b1;
            state_d   = STOP_A;
          end else if (NACK_ABORT && !ackFlag_q) begin
            state_d = STOP_A;
          end else begin
            byteIdx_d = byteIdx_q + 2'd1;
            state_d   = (byteIdx_q == 2'd1) ? RS_A : B_SETUP;
          end
        end
      end
      RS_A: begin
        sclDrive = 1'b0;
        state_d  = RS_B;
      end
      RS_B: begin
        state_d = RS_C;
      end
      RS_C: begin
        sdaDrive = 1'b0;
        state_d  = RS_D;
      end
      RS_D: begin
        sdaDrive = 1'b0;
        sclDrive = 1'b0;
        state_d  = B_SETUP;
      end
      STOP_A: begin
        sdaDrive = 1'b0;
        sclDrive = 1'b0;
        state_d  = STOP_B;
      end
      STOP_B: begin
        sdaDrive = 1'b0;
        state_d  = STOP_C;
      end
      STOP_C: begin
        state_d = DONE;
      end
      DONE: begin
        endOk_d = 1'b1;
        ackOk_d = ackFlag_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign SDAO     = sdaDrive;
  assign SCLO     = sclDrive;
  assign END_OK   = endOk_q;
  assign RDATA8   = rdata_q;
  assign RD_VALID = rdValid_q;
  assign ACK_OK   = ackOk_q;

endmodule

// File: tb/tb_i2c_read_byte.sv
// Bench for i2c_read_byte: a bus-level I2C slave answers the read master; a second
// instance with NACK_ABORT=0 and no slave covers the non-aborting NACK path.
module tb_i2c_read_byte;

  logic       clock = 1'b0;
  logic       reset;
  logic       goA, goB;
  logic [7:0] slaveAddress, pointer;
  logic       sdaiA;
  logic       sdaoA, scloA, endOkA, rdValidA, ackOkA;
  logic [7:0] rdataA;
  logic       sdaoB, scloB, endOkB, rdValidB, ackOkB;
  logic [7:0] rdataB;

  int checks = 0;
  int failures = 0;

  bit         slaveEnable;
  logic       slaveSda = 1'b1;
  logic       prevScl = 1'b1, prevSda = 1'b1;
  int         sBit, sByte;
  bit         sActive, sRead, sReadPend, sMatch;
  logic [7:0] sShift, sPtr, sTx;
  logic [7:0] seenBytes[$];
  int         startCnt, stopCnt, bothToggle;
  logic       nackSeen;

  always #5 clock = ~clock;

  assign sdaiA = sdaoA & (slaveSda | ~slaveEnable);

  i2c_read_byte dutA (
    .PT_CK(clock), .RESET(reset), .GO(goA), .SLAVE_ADDRESS(slaveAddress), .POINTER(pointer),
    .SDAI(sdaiA), .SDAO(sdaoA), .SCLO(scloA), .END_OK(endOkA), .RDATA8(rdataA),
    .RD_VALID(rdValidA), .ACK_OK(ackOkA)
  );

  i2c_read_byte #(.NACK_ABORT(1'b0), .RDATA_INIT(8'h5A)) dutB (
    .PT_CK(clock), .RESET(reset), .GO(goB), .SLAVE_ADDRESS(slaveAddress), .POINTER(pointer),
    .SDAI(1'b1), .SDAO(sdaoB), .SCLO(scloB), .END_OK(endOkB), .RDATA8(rdataB),
    .RD_VALID(rdValidB), .ACK_OK(ackOkB)
  );

  function automatic logic [7:0] slaveReg(input logic [7:0] ptr);
    case (ptr)
      8'h07:   return 8'hA5;
      8'h10:   return 8'h00;
      8'h11:   return 8'hFF;
      default: return 8'h3C;
    endcase
  endfunction

  // Slave at 7'h4C plus bus monitor on dutA, both reacting to the bus level only.
  always @(negedge clock) begin
    if (reset) begin
      sActive  = 1'b0;
      slaveSda = 1'b1;
    end else begin
      if (scloA != prevScl && sdaoA != prevSda) bothToggle++;
      if (prevScl && scloA && prevSda && !sdaoA) begin
        startCnt++;
        sActive = 1'b1; sBit = 0; sByte = 0; sRead = 1'b0; sReadPend = 1'b0; slaveSda = 1'b1;
      end else if (prevScl && scloA && !prevSda && sdaoA) begin
        stopCnt++;
        sActive = 1'b0; slaveSda = 1'b1;
      end else if (!prevScl && scloA && sActive) begin
        if (sBit < 8 && !sRead) sShift = {sShift[6:0], sdaoA};
        if (sBit == 8 && sRead) nackSeen = sdaoA;
        sBit++;
      end else if (prevScl && !scloA && sActive) begin
        if (sBit == 8 && !sRead) begin
          seenBytes.push_back(sShift);
          if (sByte == 0) begin
            sMatch    = (sShift[7:1] == 7'h4C);
            sReadPend = sShift[0];
          end else if (sByte == 1) begin
            sPtr = sShift;
          end
          slaveSda = ~sMatch;
        end else if (sBit == 9) begin
          sBit = 0;
          sByte++;
          if (sReadPend && sMatch && !sRead) begin
            sRead    = 1'b1;
            sTx      = slaveReg(sPtr);
            slaveSda = sTx[7];
          end else begin
            slaveSda = 1'b1;
          end
        end else if (sRead && sBit >= 1 && sBit <= 7) begin
          slaveSda = sTx[7 - sBit];
        end else if (sRead && sBit == 8) begin
          slaveSda = 1'b1;
        end
      end
    end
    prevScl = scloA;
    prevSda = sdaoA;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Launches one read on the chosen instance and measures the END_OK low window.
  task automatic applyStimulus(input bit useB, input logic [7:0] ptr, input int holdCycles,
                               input bit toggleGo, output int lowCycles, output int validPulses,
                               output bit timedOut);
    logic endOk;
    pointer = ptr;
    startCnt = 0; stopCnt = 0; bothToggle = 0; nackSeen = 1'b0;
    seenBytes.delete();
    if (useB) goB = 1'b1; else goA = 1'b1;
    repeat (holdCycles) @(negedge clock);
    goA = 1'b0; goB = 1'b0;
    lowCycles = 0; validPulses = 0; timedOut = 1'b1;
    endOk = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      endOk = useB ? endOkB : endOkA;
      if (!endOk) begin
        timedOut = 1'b0;
        break;
      end
    end
    if (!timedOut) begin
      while (!endOk && lowCycles < 400) begin
        lowCycles++;
        if (useB ? rdValidB : rdValidA) validPulses++;
        if (toggleGo) begin
          if (useB) goB = ((lowCycles % 8) == 3) && lowCycles < 100;
          else      goA = ((lowCycles % 8) == 3) && lowCycles < 100;
        end
        @(negedge clock);
        endOk = useB ? endOkB : endOkA;
      end
      if (!endOk) timedOut = 1'b1;
    end
    goA = 1'b0; goB = 1'b0;
  endtask

  initial begin
    int  low, pulses, extraLow;
    bit  timedOut;
    logic started;

    reset = 1'b1; goA = 1'b0; goB = 1'b0; slaveEnable = 1'b1;
    slaveAddress = 8'h99; pointer = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_sdao", 32'(sdaoA), 32'd1);
    checkOutput("rst_sclo", 32'(scloA), 32'd1);
    checkOutput("rst_endok", 32'(endOkA), 32'd1);
    checkOutput("rst_rdata", 32'(rdataA), 32'h00);
    checkOutput("rst_rdvalid", 32'(rdValidA), 32'd0);
    checkOutput("rst_ackok", 32'(ackOkA), 32'd0);
    checkOutput("rst_rdataB_init", 32'(rdataB), 32'h5A);

    // Normal read of register 0x07 from a cooperating slave.
    applyStimulus(1'b0, 8'h07, 1, 1'b0, low, pulses, timedOut);
    checkOutput("t1_timeout", 32'(timedOut), 32'd0);
    checkOutput("t1_low_cycles", 32'(low), 32'd118);
    checkOutput("t1_rdvalid_pulses", 32'(pulses), 32'd1);
    checkOutput("t1_rdata", 32'(rdataA), 32'hA5);
    checkOutput("t1_ackok", 32'(ackOkA), 32'd1);
    checkOutput("t1_bytes_seen", 32'(seenBytes.size()), 32'd3);
    checkOutput("t1_byte0", 32'(seenBytes.size() > 0 ? seenBytes[0] : 8'hEE), 32'h98);
    checkOutput("t1_byte1", 32'(seenBytes.size() > 1 ? seenBytes[1] : 8'hEE), 32'h07);
    checkOutput("t1_byte2", 32'(seenBytes.size() > 2 ? seenBytes[2] : 8'hEE), 32'h99);
    checkOutput("t1_master_nack", 32'(nackSeen), 32'd1);
    checkOutput("t1_starts", 32'(startCnt), 32'd2);
    checkOutput("t1_stops", 32'(stopCnt), 32'd1);
    checkOutput("t1_both_toggle", 32'(bothToggle), 32'd0);

    // No slave, aborting instance: STOP straight after the address ACK slot.
    slaveEnable = 1'b0;
    applyStimulus(1'b0, 8'h07, 1, 1'b0, low, pulses, timedOut);
    checkOutput("t2_timeout", 32'(timedOut), 32'd0);
    checkOutput("t2_low_cycles", 32'(low), 32'd33);
    checkOutput("t2_rdvalid_pulses", 32'(pulses), 32'd0);
    checkOutput("t2_rdata_kept", 32'(rdataA), 32'hA5);
    checkOutput("t2_ackok", 32'(ackOkA), 32'd0);
    checkOutput("t2_bytes_seen", 32'(seenBytes.size()), 32'd1);
    checkOutput("t2_starts", 32'(startCnt), 32'd1);
    checkOutput("t2_stops", 32'(stopCnt), 32'd1);
    checkOutput("t2_both_toggle", 32'(bothToggle), 32'd0);
    slaveEnable = 1'b1;

    // No slave, non-aborting instance: full sequence reads all ones.
    applyStimulus(1'b1, 8'h07, 1, 1'b0, low, pulses, timedOut);
    checkOutput("t3_timeout", 32'(timedOut), 32'd0);
    checkOutput("t3_low_cycles", 32'(low), 32'd118);
    checkOutput("t3_rdvalid_pulses", 32'(pulses), 32'd1);
    checkOutput("t3_rdata", 32'(rdataB), 32'hFF);
    checkOutput("t3_ackok", 32'(ackOkB), 32'd0);

    // Reset in the SCL-low phase of data byte bit 4.
    pointer = 8'h07;
    goA = 1'b1;
    @(negedge clock);
    goA = 1'b0;
    started = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (!endOkA) begin
        started = 1'b1;
        break;
      end
    end
    checkOutput("t4_started", 32'(started), 32'd1);
    repeat (101) @(negedge clock);
    checkOutput("t4_pre_sclo", 32'(scloA), 32'd0);
    checkOutput("t4_pre_endok", 32'(endOkA), 32'd0);
    #1 reset = 1'b1;
    #1;
    checkOutput("t4_rst_sdao", 32'(sdaoA), 32'd1);
    checkOutput("t4_rst_sclo", 32'(scloA), 32'd1);
    checkOutput("t4_rst_endok", 32'(endOkA), 32'd1);
    checkOutput("t4_rst_rdata", 32'(rdataA), 32'h00);
    checkOutput("t4_rst_rdataB", 32'(rdataB), 32'h5A);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    applyStimulus(1'b0, 8'h07, 1, 1'b0, low, pulses, timedOut);
    checkOutput("t4_clean_timeout", 32'(timedOut), 32'd0);
    checkOutput("t4_clean_low_cycles", 32'(low), 32'd118);
    checkOutput("t4_clean_rdata", 32'(rdataA), 32'hA5);
    checkOutput("t4_clean_ackok", 32'(ackOkA), 32'd1);

    // GO held then toggled mid-transaction, followed by a back-to-back read.
    applyStimulus(1'b0, 8'h10, 4, 1'b1, low, pulses, timedOut);
    checkOutput("t5a_timeout", 32'(timedOut), 32'd0);
    checkOutput("t5a_low_cycles", 32'(low), 32'd118);
    checkOutput("t5a_rdvalid_pulses", 32'(pulses), 32'd1);
    checkOutput("t5a_rdata", 32'(rdataA), 32'h00);
    checkOutput("t5a_ackok", 32'(ackOkA), 32'd1);
    applyStimulus(1'b0, 8'h11, 1, 1'b0, low, pulses, timedOut);
    checkOutput("t5b_timeout", 32'(timedOut), 32'd0);
    checkOutput("t5b_low_cycles", 32'(low), 32'd118);
    checkOutput("t5b_rdata", 32'(rdataA), 32'hFF);
    checkOutput("t5b_master_nack", 32'(nackSeen), 32'd1);
    checkOutput("t5b_starts", 32'(startCnt), 32'd2);
    checkOutput("t5b_both_toggle", 32'(bothToggle), 32'd0);
    extraLow = 0;
    repeat (20) begin
      @(negedge clock);
      if (!endOkA) extraLow++;
    end
    checkOutput("t5_no_extra_txn", 32'(extraLow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
